// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and constants for the keyboard sequencer
// Purpose: prefix FSM state type and scan-code / LUT constants used by
//          keyboard_ctrl and convert_to_binary.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } prefix_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] EMPTY_CODE = 8'h00;

    localparam logic [3:0] LUT_EMPTY  = 4'hF;
    localparam logic [3:0] LUT_ERROR  = 4'hE;

endpackage

// File: rtl/convert_to_binary.sv
// rtl/convert_to_binary.sv - PS/2 set-2 digit scan code to binary lookup
// Purpose: combinational LUT shared by the display sequencer.
// Ports:
//   code  in  8  scan code to translate
//   value out 4  0-9 for digit keys, LUT_EMPTY for EMPTY_CODE, LUT_ERROR otherwise
module convert_to_binary
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] value
);

    always_comb begin
        value = LUT_ERROR;
        case (code)
            EMPTY_CODE: value = LUT_EMPTY;
            8'h45:      value = 4'd0;
            8'h16:      value = 4'd1;
            8'h1E:      value = 4'd2;
            8'h26:      value = 4'd3;
            8'h25:      value = 4'd4;
            8'h2E:      value = 4'd5;
            8'h36:      value = 4'd6;
            8'h3D:      value = 4'd7;
            8'h3E:      value = 4'd8;
            8'h46:      value = 4'd9;
            default:    value = LUT_ERROR;
        endcase
    end

endmodule

// File: rtl/digit_refresh_timer.sv
// rtl/digit_refresh_timer.sv - digit slot timer for the multiplexed display
// Purpose: counts REFRESH_CYCLES clocks per slot and steps digit_idx through
//          0..NUM_DIGITS-1 on every slot wrap.
// Ports:
//   clk       in  1  system clock
//   rst_n     in  1  synchronous active-low reset
//   digit_idx out    index of the digit owning the current slot
module digit_refresh_timer #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] refresh_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keyboard_ctrl.sv
// rtl/keyboard_ctrl.sv - PS/2 scan-code sequencer driving a multiplexed display
// Purpose: decodes make/break/extended prefixes, keeps the last NUM_DIGITS
//          accepted make codes, and time-shares an external LUT across digits.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   valid_code_in   one-cycle strobe qualifying scan_code_in
//   scan_code_in    received PS/2 byte
//   lut_code_out    code of the digit in the current slot, to the shared LUT
//   lut_binary_in   LUT result for lut_code_out
//   digit_an_out    registered active-low one-hot digit enable
//   digit_bin_out   registered value for the enabled digit
//   key_event_out   registered pulse per accepted make code
module keyboard_ctrl
    import kbd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_code_in,
    input  logic [7:0]            scan_code_in,
    output logic [7:0]            lut_code_out,
    input  logic [3:0]            lut_binary_in,
    output logic [NUM_DIGITS-1:0] digit_an_out,
    output logic [3:0]            digit_bin_out,
    output logic                  key_event_out
);

    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    prefix_state_t state, next_state;

    logic [7:0] buffer [NUM_DIGITS];
    logic [7:0] last_pressed;
    logic       accept;
    logic       release_hit;

    logic [$clog2(NUM_DIGITS)-1:0] digit_idx;

    digit_refresh_timer #(
        .NUM_DIGITS     (NUM_DIGITS),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_idx (digit_idx)
    );

    assign lut_code_out = buffer[digit_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A repeated make of the held key is typematic and ignored; a break of
    // the held key clears last_pressed so the next press is accepted again.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        release_hit = 1'b0;
        if (valid_code_in) begin
            case (state)
                IDLE: begin
                    if (scan_code_in == BREAK_CODE) begin
                        next_state = BREAK;
                    end else if (scan_code_in == EXT_CODE) begin
                        next_state = EXT;
                    end else if (scan_code_in != last_pressed) begin
                        accept = 1'b1;
                    end
                end
                BREAK: begin
                    next_state  = IDLE;
                    release_hit = (scan_code_in == last_pressed);
                end
                EXT:       next_state = (scan_code_in == BREAK_CODE) ? EXT_BREAK : IDLE;
                EXT_BREAK: next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pressed  <= EMPTY_CODE;
            key_event_out <= 1'b0;
            digit_an_out  <= '1;
            digit_bin_out <= LUT_EMPTY;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                buffer[i] <= EMPTY_CODE;
            end
        end else begin
            key_event_out <= accept;
            // Anode and value are both taken from the same slot, so they
            // always move together.
            digit_an_out  <= ~(AN_ONE << digit_idx);
            digit_bin_out <= lut_binary_in;
            if (accept) begin
                buffer[0]    <= scan_code_in;
                for (int i = 1; i < NUM_DIGITS; i++) begin
                    buffer[i] <= buffer[i-1];
                end
                last_pressed <= scan_code_in;
            end else if (release_hit) begin
                last_pressed <= EMPTY_CODE;
            end
        end
    end

endmodule
